// File: rtl/comparator_4b.sv
// Registered magnitude comparator.
// Compares operands A and B either as unsigned values or, when SIGNED_EN is
// set and sgn is high, as two's-complement values. The relation is registered
// one cycle after an accepted sample, together with a one-cycle out_valid
// pulse. The only state in the block is the four output registers.
module comparator_4b #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  input  logic             sgn,
  output logic             ET,
  output logic             GT,
  output logic             LT,
  output logic             out_valid
);

  // Flipping the sign bit maps the two's-complement range onto an
  // order-preserving unsigned range: -2^(W-1) becomes 0 and 2^(W-1)-1
  // becomes all-ones. After that a single unsigned compare serves both
  // modes, and no subtraction (hence no overflow) is ever involved.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  logic             signed_mode;
  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] gt_hit;
  logic [WIDTH-1:0] lt_hit;
  logic             rel_et;
  logic             rel_gt;
  logic             rel_lt;

  logic et_reg;
  logic gt_reg;
  logic lt_reg;
  logic out_valid_reg;

  // sgn only has an effect when the signed capability is built in.
  assign signed_mode = SIGNED_EN & sgn;

  assign a_key = A ^ (signed_mode ? SIGN_MASK : '0);
  assign b_key = B ^ (signed_mode ? SIGN_MASK : '0);
  assign diff  = a_key ^ b_key;

  // The most significant differing bit decides the relation: bit gi wins
  // when every bit above it matches and the operands differ at gi.
  // Equality is the absence of any difference, which is the same in both
  // modes because the sign flip is applied to both operands.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic above_equal;
      assign above_equal = ((diff >> (gi + 1)) == '0);
      assign gt_hit[gi]  = above_equal &  a_key[gi] & ~b_key[gi];
      assign lt_hit[gi]  = above_equal & ~a_key[gi] &  b_key[gi];
    end
  endgenerate

  assign rel_et = (diff == '0);
  assign rel_gt = |gt_hit;
  assign rel_lt = |lt_hit;

  // Output registers: reset clears everything, an accepted sample loads a
  // new one-hot relation, otherwise the relation holds and out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      et_reg        <= 1'b0;
      gt_reg        <= 1'b0;
      lt_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        et_reg <= rel_et;
        gt_reg <= rel_gt;
        lt_reg <= rel_lt;
      end
    end
  end

  assign ET        = et_reg;
  assign GT        = gt_reg;
  assign LT        = lt_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_comparator_4b.sv
// Self-checking bench for comparator_4b: a behavioural integer model checked
// every cycle, hand-computed literal cases, randomized traffic with resets,
// and an exhaustive back-to-back sweep in both modes.
module tb_comparator_4b;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_valid = 1'b0;
  logic         sgn = 1'b0;
  logic         ET;
  logic         GT;
  logic         LT;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  // model state
  bit m_known = 0;
  bit m_et = 0;
  bit m_gt = 0;
  bit m_lt = 0;
  bit m_ov = 0;

  comparator_4b #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .in_valid(in_valid),
    .sgn(sgn),
    .ET(ET),
    .GT(GT),
    .LT(LT),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Numeric value of an operand under the selected interpretation.
  function automatic int value_of(input logic [W-1:0] v, input bit s);
    int x;
    x = int'(v);
    if (s && x >= (1 << (W - 1))) x = x - (1 << W);
    return x;
  endfunction

  // Behavioural model: evaluates the relation on each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1;
      m_et = 0; m_gt = 0; m_lt = 0; m_ov = 0;
    end else if (m_known) begin
      m_ov = in_valid;
      if (in_valid) begin
        int av, bv;
        av = value_of(A, sgn);
        bv = value_of(B, sgn);
        m_et = (av == bv);
        m_gt = (av > bv);
        m_lt = (av < bv);
      end
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT against model on every cycle after the first reset edge.
  always @(negedge clk) begin
    if (m_known) begin
      check("model_ET", ET, m_et);
      check("model_GT", GT, m_gt);
      check("model_LT", LT, m_lt);
      check("model_out_valid", out_valid, m_ov);
      if (out_valid === 1'b1)
        check("one_hot", logic'((32'(ET) + 32'(GT) + 32'(LT)) == 1), 1'b1);
    end
  end

  // Present inputs on the falling edge so they are stable at the next rising edge.
  task automatic drive(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic v);
    @(negedge clk);
    rst_n = r; A = a; B = b; sgn = s; in_valid = v;
  endtask

  // Literal expectation just after the edge that samples the last drive.
  task automatic lit(input string name, input bit e_et, input bit e_gt,
                     input bit e_lt, input bit e_ov);
    @(posedge clk);
    #1;
    $display("txn %s: ET=%b GT=%b LT=%b out_valid=%b", name, ET, GT, LT, out_valid);
    check({name, "_ET"}, ET, e_et);
    check({name, "_GT"}, GT, e_gt);
    check({name, "_LT"}, LT, e_lt);
    check({name, "_ov"}, out_valid, e_ov);
    checks++;
    if ({m_et, m_gt, m_lt, m_ov} != {e_et, e_gt, e_lt, e_ov}) begin
      errors++;
      $display("FAIL %s_model: got %b%b%b%b expected %b%b%b%b", name,
               m_et, m_gt, m_lt, m_ov, e_et, e_gt, e_lt, e_ov);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 4'b0000, 4'b0000, 0, 0);
    lit("reset", 0, 0, 0, 0);

    // unsigned, back-to-back
    drive(1, 4'b0000, 4'b0000, 0, 1); lit("u_0_0", 1, 0, 0, 1);
    drive(1, 4'b0101, 4'b0011, 0, 1); lit("u_5_3", 0, 1, 0, 1);
    drive(1, 4'b0010, 4'b0100, 0, 1); lit("u_2_4", 0, 0, 1, 1);
    drive(1, 4'b1111, 4'b1111, 0, 1); lit("u_15_15", 1, 0, 0, 1);
    drive(1, 4'b1010, 4'b0111, 0, 1); lit("u_10_7", 0, 1, 0, 1);
    drive(1, 4'b1000, 4'b1100, 0, 1); lit("u_8_12", 0, 0, 1, 1);
    drive(1, 4'b0000, 4'b1111, 0, 1); lit("u_0_15", 0, 0, 1, 1);

    // signed
    drive(1, 4'b1010, 4'b0111, 1, 1); lit("s_m6_7", 0, 0, 1, 1);
    drive(1, 4'b1000, 4'b0111, 1, 1); lit("s_m8_7", 0, 0, 1, 1);
    drive(1, 4'b0000, 4'b1111, 1, 1); lit("s_0_m1", 0, 1, 0, 1);
    drive(1, 4'b1000, 4'b1000, 1, 1); lit("s_m8_m8", 1, 0, 0, 1);
    drive(1, 4'b0111, 4'b1000, 1, 1); lit("s_7_m8", 0, 1, 0, 1);

    // hold
    drive(1, 4'b0101, 4'b0011, 0, 1); lit("hold_load", 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0000, 4'b1111, 0, 0); lit("hold", 0, 1, 0, 0);
    end

    // reset with a sample presented, then first sample after release
    drive(0, 4'b0101, 4'b0011, 0, 1); lit("rst_drop", 0, 0, 0, 0);
    drive(0, 4'b0101, 4'b0011, 0, 1); lit("rst_hold", 0, 0, 0, 0);
    drive(1, 4'b0010, 4'b0100, 0, 1); lit("post_rst", 0, 0, 1, 1);
    // mid-stream reset drops the pending sample
    drive(1, 4'b1111, 4'b0000, 0, 1); lit("pre_mid", 0, 1, 0, 1);
    drive(0, 4'b0000, 4'b1111, 0, 1); lit("mid_rst", 0, 0, 0, 0);

    // randomized traffic, occasional resets
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 19) != 0), W'($urandom), W'($urandom),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
    end

    // exhaustive back-to-back sweep in both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < (1 << W); a++)
        for (int b = 0; b < (1 << W); b++)
          drive(1, W'(a), W'(b), logic'(s), 1);
    drive(1, 4'b0000, 4'b0000, 0, 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
